// File: rtl/mem_mock_responder.sv
// Memory slave model for the matrix-multiplier operand buses: toggling-ack
// handshake, backing RAM with per-entry valid bits, and pattern fill for unwritten words.
module mem_mock_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [2:0]        paddr,
  input  logic [15:0]       pwdata,
  output logic [15:0]       prdata,
  output logic              pready
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              ack_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [15:0]       prdata_reg;
  logic [2:0]        ctrl_reg;
  logic [15:0]       seed_reg;
  logic [15:0]       stride_reg;
  logic [15:0]       rcount_reg;
  logic [15:0]       wcount_reg;
  logic [15:0]       lfsr_reg;
  logic              valid_reg [DEPTH];
  logic [DATA_W-1:0] ram [DEPTH];

  logic              apb_wr, apb_rd, ctrl_wr, seed_wr, stride_wr, clear;
  logic              fire, wr_fire, rd_fire, hit;
  logic [IDX_W-1:0]  idx;
  logic [15:0]       seed_load, lfsr_load, lfsr_base, lfsr_step, lfsr_next;
  logic [15:0]       inc_prod, pat16, reg_rdata, rcount_next, wcount_next;

  assign apb_wr    = psel & penable & pwrite;
  assign apb_rd    = psel & ~pwrite;
  assign ctrl_wr   = apb_wr && (paddr == 3'd0);
  assign seed_wr   = apb_wr && (paddr == 3'd1);
  assign stride_wr = apb_wr && (paddr == 3'd2);
  assign clear     = apb_wr && (paddr == 3'd5) && pwdata[0];

  // A transfer is performed on the edge that raises ack; the master sees it one cycle later.
  assign fire    = mem_req & ctrl_reg[0] & ~ack_reg;
  assign wr_fire = fire & mem_we;
  assign rd_fire = fire & ~mem_we;
  assign idx     = mem_addr[IDX_W-1:0];
  assign hit     = valid_reg[idx] & ~clear;

  // CLEAR and SEED writes reload the LFSR before any same-cycle read consumes it.
  assign seed_load = seed_wr ? pwdata : seed_reg;
  assign lfsr_load = (seed_load == 16'h0000) ? 16'h0001 : seed_load;
  assign lfsr_base = (clear | seed_wr) ? lfsr_load : lfsr_reg;
  assign lfsr_step = {1'b0, lfsr_base[15:1]} ^ (lfsr_base[0] ? 16'hB400 : 16'h0000);
  assign lfsr_next = (rd_fire && !hit && ctrl_reg[2:1] == 2'd2) ? lfsr_step : lfsr_base;

  assign inc_prod = 16'(stride_reg * mem_addr);

  always_comb begin
    case (ctrl_reg[2:1])
      2'd0:    pat16 = seed_reg + inc_prod;
      2'd1:    pat16 = seed_reg;
      2'd2:    pat16 = lfsr_base;
      default: pat16 = 16'h0000;
    endcase
  end

  assign rcount_next = (clear ? 16'h0000 : rcount_reg) + {15'd0, rd_fire};
  assign wcount_next = (clear ? 16'h0000 : wcount_reg) + {15'd0, wr_fire};

  always_comb begin
    case (paddr)
      3'd0:    reg_rdata = {13'd0, ctrl_reg};
      3'd1:    reg_rdata = seed_reg;
      3'd2:    reg_rdata = stride_reg;
      3'd3:    reg_rdata = rcount_reg;
      3'd4:    reg_rdata = wcount_reg;
      default: reg_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_reg    <= 1'b0;
      rdata_reg  <= '0;
      prdata_reg <= 16'h0000;
      ctrl_reg   <= 3'b001;
      seed_reg   <= 16'h0000;
      stride_reg <= 16'h0001;
      rcount_reg <= 16'h0000;
      wcount_reg <= 16'h0000;
      lfsr_reg   <= 16'h0001;
    end else begin
      ack_reg <= (mem_req & ctrl_reg[0]) ? ~ack_reg : 1'b0;
      if (rd_fire) rdata_reg <= hit ? ram[idx] : DATA_W'(pat16);
      if (apb_rd) prdata_reg <= reg_rdata;
      if (ctrl_wr) ctrl_reg <= pwdata[2:0];
      if (seed_wr) seed_reg <= pwdata;
      if (stride_wr) stride_reg <= pwdata;
      lfsr_reg   <= lfsr_next;
      rcount_reg <= rcount_next;
      wcount_reg <= wcount_next;
    end
  end

  // Valid bits: a same-cycle write wins over CLEAR so the written entry stays valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        valid_reg[gi] <= 1'b0;
      else if (wr_fire && idx == IDX_W'(gi))
        valid_reg[gi] <= 1'b1;
      else if (clear)
        valid_reg[gi] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) ram[idx] <= mem_wdata;
  end

  assign mem_ack   = ack_reg;
  assign mem_rdata = rdata_reg;
  assign prdata    = prdata_reg;
  assign pready    = 1'b1;

endmodule

// File: tb/tb_mem_mock_responder.sv
// Randomized bench for mem_mock_responder against a transaction-level model.
module tb_mem_mock_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [15:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  paddr = '0;
  logic [15:0] pwdata = '0;
  logic [15:0] prdata;
  logic        pready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_mock_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  // Reference model state
  logic [15:0] m_ram [256];
  bit          m_valid [256];
  logic [15:0] m_ctrl, m_seed, m_stride, m_rcnt, m_wcnt, m_lfsr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_ctrl = 16'h1; m_seed = 0; m_stride = 1; m_rcnt = 0; m_wcnt = 0; m_lfsr = 1;
    for (int i = 0; i < 256; i++) m_valid[i] = 0;
  endtask

  task automatic model_read(input logic [15:0] addr, output logic [15:0] exp);
    int idx;
    idx = addr % 256;
    m_rcnt = m_rcnt + 16'd1;
    if (m_valid[idx]) exp = m_ram[idx];
    else begin
      case ((m_ctrl >> 1) & 3)
        0: exp = 16'((int'(m_seed) + int'(m_stride) * int'(addr)) & 32'hFFFF);
        1: exp = m_seed;
        2: begin exp = m_lfsr; m_lfsr = lfsr_adv(m_lfsr); end
        default: exp = 0;
      endcase
    end
  endtask

  task automatic model_write(input logic [15:0] addr, input logic [15:0] d);
    m_ram[addr % 256] = d;
    m_valid[addr % 256] = 1;
    m_wcnt = m_wcnt + 16'd1;
  endtask

  task automatic model_apb_write(input logic [2:0] a, input logic [15:0] d);
    case (a)
      3'd0: m_ctrl = d & 16'h7;
      3'd1: begin m_seed = d; m_lfsr = (d == 0) ? 16'h1 : d; end
      3'd2: m_stride = d;
      3'd5: if (d[0]) begin
        for (int i = 0; i < 256; i++) m_valid[i] = 0;
        m_rcnt = 0; m_wcnt = 0;
        m_lfsr = (m_seed == 0) ? 16'h1 : m_seed;
      end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] model_apb_read(input logic [2:0] a);
    case (a)
      3'd0: return m_ctrl;
      3'd1: return m_seed;
      3'd2: return m_stride;
      3'd3: return m_rcnt;
      3'd4: return m_wcnt;
      default: return 16'h0;
    endcase
  endfunction

  task automatic apb_write(input logic [2:0] a, input logic [15:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
    model_apb_write(a, d);
    $display("apb wr addr=%0d data=%h", a, d);
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [15:0] d);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    d = prdata;
    psel = 0; penable = 0;
    $display("apb rd addr=%0d data=%h", a, d);
  endtask

  task automatic apb_check(input logic [2:0] a, input string tag);
    logic [15:0] d;
    apb_read(a, d);
    check_val(tag, d, model_apb_read(a));
  endtask

  // One full memory transfer: request, bounded wait for ack, check, release.
  task automatic mem_xfer(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd);
    int n;
    logic [15:0] exp;
    mem_req = 1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!mem_ack && n < 8);
    check_val("ack_latency", n, 1);
    rd = mem_rdata;
    if (we) model_write(addr, wd);
    else begin
      model_read(addr, exp);
      check_val("rdata", rd, exp);
    end
    mem_req = 0;
    @(posedge clk); #1;
    $display("mem %s addr=%h data=%h", we ? "wr" : "rd", addr, we ? wd : rd);
  endtask

  initial begin
    logic [15:0] rd, d, a16;
    logic [15:0] exp_init [6];
    logic [15:0] lfsr_exp [3];
    exp_init = '{16'h1, 16'h0, 16'h1, 16'h0, 16'h0, 16'h0};
    lfsr_exp = '{16'h0001, 16'hB400, 16'h5A00};
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset_n = 1;
    @(posedge clk); #1;

    // Reset state
    check_val("rst_ack", mem_ack, 0);
    check_val("rst_rdata", mem_rdata, 0);
    check_val("rst_prdata", prdata, 0);
    check_val("rst_pready", pready, 1);
    for (int i = 0; i < 6; i++) begin
      apb_read(3'(i), d);
      check_val($sformatf("rst_reg%0d", i), d, exp_init[i]);
    end

    // Mode 0 with request held: completions on cycles 1, 3, 5
    apb_write(3'd1, 16'h0010);
    apb_write(3'd2, 16'h0002);
    mem_req = 1; mem_we = 0; mem_addr = 16'h0005;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      check_val($sformatf("held_ack_c%0d", c), mem_ack, c % 2);
      if (mem_ack) begin
        check_val("held_rdata", mem_rdata, 16'h001A);
        model_read(16'h0005, rd);
      end
    end
    mem_req = 0;
    @(posedge clk); #1;
    apb_read(3'd3, d);
    check_val("held_rcount", d, 3);

    // Aliased write/read and CLEAR
    mem_xfer(1, 16'h0103, 16'hBEEF, rd);
    mem_xfer(0, 16'h0003, 16'h0, rd);
    check_val("alias_rdata", rd, 16'hBEEF);
    apb_read(3'd4, d);
    check_val("alias_wcount", d, 1);
    apb_write(3'd5, 16'h0001);
    mem_xfer(0, 16'h0003, 16'h0, rd);
    check_val("clr_pattern", rd, 16'h0016);
    apb_read(3'd4, d);
    check_val("clr_wcount", d, 0);

    // LFSR mode, seed 0
    apb_write(3'd1, 16'h0000);
    apb_write(3'd0, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      mem_xfer(0, 16'(16'h0040 + i), 16'h0, rd);
      check_val($sformatf("lfsr%0d", i), rd, lfsr_exp[i]);
    end

    // Disabled: request ignored for 10 cycles, then re-enable
    apb_write(3'd0, 16'h0000);
    mem_req = 1; mem_we = 0; mem_addr = 16'h0050;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_ack) check_val("dis_ack", mem_ack, 0);
    end
    check_val("dis_ack_end", mem_ack, 0);
    apb_check(3'd3, "dis_rcount");
    apb_write(3'd0, 16'h0003);
    check_val("reen_ack0", mem_ack, 0);
    @(posedge clk); #1;
    check_val("reen_ack1", mem_ack, 1);
    model_read(16'h0050, rd);
    check_val("reen_rdata", mem_rdata, rd);
    mem_req = 0;
    @(posedge clk); #1;

    // Randomized traffic
    apb_write(3'd0, 16'h0001);
    for (int t = 0; t < 200; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a16 = 16'(($urandom & 32'hFF00) | $urandom_range(0, 15));
      if (kind < 4) mem_xfer(1, a16, 16'($urandom), rd);
      else if (kind < 8) mem_xfer(0, a16, 16'h0, rd);
      else if (kind == 8) begin
        case ($urandom_range(0, 4))
          0: apb_write(3'd0, 16'(1 | ($urandom_range(0, 3) << 1)));
          1: apb_write(3'd1, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
          2: apb_write(3'd2, 16'($urandom_range(0, 7)));
          3: apb_write(3'd5, 16'($urandom & 3));
          default: apb_write(3'($urandom_range(3, 7)), 16'($urandom));
        endcase
      end else apb_check(3'($urandom_range(0, 7)), "rand_reg");
    end
    for (int i = 0; i < 8; i++) apb_check(3'(i), "final_reg");

    // Asynchronous reset while ack is high
    mem_req = 1; mem_we = 0; mem_addr = 16'h0007;
    @(posedge clk); #1;
    check_val("pre_rst_ack", mem_ack, 1);
    reset_n = 0;
    #1;
    check_val("async_ack", mem_ack, 0);
    check_val("async_rdata", mem_rdata, 0);
    check_val("async_prdata", prdata, 0);
    mem_req = 0;
    @(posedge clk); #2;
    reset_n = 1;
    model_reset();
    @(posedge clk); #1;
    apb_check(3'd0, "post_rst_ctrl");
    apb_check(3'd3, "post_rst_rcount");
    apb_check(3'd4, "post_rst_wcount");
    check_val("post_rst_ack", mem_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_mock_responder.md
Name: mem_mock_responder

Overview:
- Simulation-grade memory slave model for the matrix-multiplier memory ports (A, B and C operand buses).
- Answers read/write requests with a toggling-ack handshake.
- Read data comes from a small backing RAM, or from a configurable generated pattern for locations never written.
- Configured and observed through a 3-bit-address, 16-bit-data APB slave port.

Parameters:
- ADDR_W, 16, memory bus address width.
- DATA_W, 16, memory bus data width.
- DEPTH, 256, backing RAM entries (power of two); index = mem_addr mod DEPTH.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  in  1  master request, held until completion.
- mem_we  in  1  1 = write, 0 = read; sampled with mem_req.
- mem_addr  in  ADDR_W  word address.
- mem_wdata  in  DATA_W  write data.
- mem_ack  out  1  completion strobe.
- mem_rdata  out  DATA_W  read data, valid when mem_ack=1 for a read.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB write.
- paddr  in  3  APB register address.
- pwdata  in  16  APB write data.
- prdata  out  16  APB read data.
- pready  out  1  tied 1, no wait states.

Behaviour:
- Reset values:
  - mem_ack=0, mem_rdata=0, prdata=0.
  - CTRL=0x0001 (enabled, mode 0), SEED=0, STRIDE=1, counters=0.
  - All RAM valid bits cleared; LFSR=0x0001.
  - RAM contents are not reset.
- Handshake:
  - Each cycle with mem_req=1 and CTRL.en=1: mem_ack <= ~mem_ack.
  - If mem_req=0 or en=0: mem_ack <= 0.
  - A transfer completes on any cycle where mem_req=1 and mem_ack=1 (first completion 1 cycle after req rises, then every 2nd cycle while req stays high).
  - The master deasserts or changes its request after seeing ack.
- Write completion:
  - RAM[idx] <= mem_wdata; valid[idx] <= 1; WCOUNT++.
  - The ack is registered in the same edge that sets it; the write is performed at that edge.
- Read completion:
  - mem_rdata is registered together with the ack (same edge) and holds until the next read.
  - If valid[idx]=1, mem_rdata = RAM[idx].
  - Otherwise mem_rdata is the pattern value, selected by CTRL.mode:
    - mode 0 (INC): (SEED + STRIDE*mem_addr) truncated to DATA_W.
    - mode 1 (CONST): SEED.
    - mode 2 (LFSR): current LFSR value; the LFSR advances after the read.
    - mode 3 (ZERO): 0.
  - RCOUNT++ on every read.
- Pattern value widths: 16-bit pattern values are zero-extended to DATA_W if DATA_W>16 and truncated otherwise.
- LFSR:
  - 16-bit Galois, right shift, taps 0xB400.
  - Advances only on an unwritten-location read in mode 2.
  - Loaded from SEED on a SEED write or a CLEAR; a SEED of 0 loads 0x0001.
- APB:
  - Write takes effect at the edge where psel&penable&pwrite.
  - prdata registered on psel&~pwrite; unmapped addresses read 0 and ignore writes.
- Registers:
  - 0 CTRL (bit0 en, bits2:1 mode).
  - 1 SEED.
  - 2 STRIDE.
  - 3 RCOUNT (RO).
  - 4 WCOUNT (RO).
  - 5 CLEAR (write of bit0=1 clears valid bits and both counters and reloads the LFSR; reads 0).
  - 6, 7 reserved.
- Counters: 16-bit, wrap 0xFFFF->0.
- Simultaneous events: an APB CLEAR in the same cycle as a write completion clears first and then applies the write (the valid bit ends set, WCOUNT=1).
- Configuration changes mid-request: a CTRL change affects the next completion; clearing en mid-request drops ack to 0 and the transfer completes only after re-enable.
- Reset mid-operation: immediate return to reset values, and any pending request is not completed.

Test Plan:
- Reset, then APB read of addresses 0–5 -> 0x0001, 0x0000, 0x0001, 0, 0, 0; mem_ack=0.
- Mode 0, SEED=0x10, STRIDE=2, read addr 5 -> ack at cycle 1 after req rises, mem_rdata=0x001A; req held, reads complete every 2 cycles; RCOUNT=3 after 3 completions.
- Write 0xBEEF to addr 0x0103, then read addr 3 (DEPTH=256) -> 0xBEEF, WCOUNT=1; write CLEAR=1 then read addr 3 again -> pattern value, WCOUNT=0.
- Mode 2, SEED=0 -> first three unwritten reads return 0x0001, 0xB400, 0x5A00.
- CTRL.en=0 with req high for 10 cycles -> mem_ack stays 0 and counters unchanged; re-enable -> ack 1 cycle later.
- Assert reset_n=0 mid-request with ack=1 -> ack and counters zero asynchronously; CTRL returns to 0x0001.
